// File: rtl/uart_recv_if.sv
// Receiver-side bundle for uart_recv.
//   din       : asynchronous serial RX line, idles high
//   data      : last correctly framed byte
//   valid     : one-cycle pulse when data updates
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : a frame is in progress
// master = the receiver, slave = the line driver / byte consumer.
interface uart_recv_if;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  din,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output din,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first. Start edge is found on the synchronised line,
// confirmed at mid start bit, then each data bit and the stop bit are sampled
// one bit period apart so every sample lands on a bit centre.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   bus_io : uart_recv_if.master (din in; data/valid/frame_err/busy out)
module uart_recv #(
    parameter int unsigned CLK_PER_BIT = 10416,
    parameter int unsigned HALF_BIT    = CLK_PER_BIT / 2
) (
    input logic         clk,
    input logic         rst,
    uart_recv_if.master bus_io
);

    localparam logic [15:0] BitLast  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(HALF_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    // Two-flop synchroniser plus one history flop for falling-edge detect.
    logic        s1_q;
    logic        s2_q;
    logic        s2_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s2_prev_q   <= 1'b1;
        end else begin
            s1_q        <= bus_io.din;
            s2_q        <= s1_q;
            s2_prev_q   <= s2_q;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    // Needs a fresh high-to-low edge, so a held-low line is ignored.
                    if (!s2_q && s2_prev_q) begin
                        state_q <= StStart;
                        cnt_q   <= 16'd0;
                    end
                end

                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= 16'd0;
                        if (!s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q              <= 16'd0;
                        shift_q[bit_cnt_q] <= s2_q;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= 16'd0;
                        state_q <= StIdle;
                        if (s2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.data      = data_q;
    assign bus_io.valid     = valid_q;
    assign bus_io.frame_err = frame_err_q;
    assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_recv.sv
module tb_uart_recv;

    localparam int Cpb     = 16;
    localparam int Half    = Cpb / 2;
    localparam int BusyExp = Half + 9 * Cpb;      // start edge state entry to stop sample
    localparam int LatExp  = BusyExp + 3;         // din fall to first valid sample

    logic clk;
    logic rst;
    uart_recv_if bus ();

    uart_recv #(
        .CLK_PER_BIT (Cpb),
        .HALF_BIT    (Half)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int last_lat = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor and scoreboard consumer.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy_run   = 0;
            prev_pulse = 1'b0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
            if (bus.valid || bus.frame_err) begin
                chk("pulse_exclusive", 32'(bus.valid & bus.frame_err), 0);
                chk("pulse_not_consecutive", 32'(prev_pulse), 0);
            end
            if (bus.valid) begin
                n_valid++;
                last_lat = cyc - fall_cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.data), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_data", 32'(bus.data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.frame_err) n_ferr++;
            prev_pulse = bus.valid | bus.frame_err;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.din  = 1'b0;
        fall_cyc = cyc;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.din = b[i];
            repeat (Cpb) @(negedge clk);
        end
        bus.din = stop;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 20 * Cpb;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int v0;
        int f0;
        bus.din = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(bus.data), 0);
        chk("reset_valid", 32'(bus.valid), 0);
        chk("reset_frame_err", 32'(bus.frame_err), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with latency and busy-length checks.
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain("drain_55");
        repeat (4) @(negedge clk);
        chk("latency_55", 32'(last_lat), 32'(LatExp));
        chk("busy_len_55", 32'(last_busy_len), 32'(BusyExp));
        chk("ferr_none_55", 32'(n_ferr), 0);
        chk("valid_cnt_55", 32'(n_valid), 1);

        // Back-to-back frames.
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_drain("drain_b2b");
        repeat (4) @(negedge clk);
        chk("valid_cnt_b2b", 32'(n_valid), 3);
        chk("ferr_none_b2b", 32'(n_ferr), 0);
        chk("data_b2b", 32'(bus.data), 32'h0F);

        // Glitch shorter than half a bit.
        bus.din = 1'b0;
        repeat (4) @(negedge clk);
        bus.din = 1'b1;
        repeat (3 * Cpb) @(negedge clk);
        chk("glitch_busy_len", 32'(last_busy_len), 32'(Half));
        chk("glitch_valid", 32'(n_valid), 3);
        chk("glitch_ferr", 32'(n_ferr), 0);
        chk("glitch_data", 32'(bus.data), 32'h0F);

        // Framing error followed by a break.
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (20 * Cpb) @(negedge clk);
        chk("ferr_cnt", 32'(n_ferr - f0), 1);
        chk("ferr_no_valid", 32'(n_valid - v0), 0);
        chk("ferr_data_held", 32'(bus.data), 32'h0F);
        chk("break_not_busy", 32'(bus.busy), 0);
        bus.din = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        chk("break_no_start", 32'(n_valid - v0 + n_ferr - f0), 1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");
        repeat (4) @(negedge clk);
        chk("data_81", 32'(bus.data), 32'h81);

        // Reset during data bit 4 of 0xFF.
        @(negedge clk);
        bus.din = 1'b0;
        repeat (Cpb) @(negedge clk);
        bus.din = 1'b1;
        repeat (4 * Cpb + Cpb / 2) @(negedge clk);
        chk("midframe_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(bus.data), 0);
        chk("midrst_valid", 32'(bus.valid), 0);
        chk("midrst_ferr", 32'(bus.frame_err), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0  = n_valid;
        repeat (12 * Cpb) @(negedge clk);
        chk("midrst_no_output", 32'(n_valid - v0), 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        wait_drain("drain_42");
        repeat (4) @(negedge clk);
        chk("valid_cnt_42", 32'(n_valid - v0), 1);

        // Streamed bytes as a 1-stop-bit sender would produce them.
        f0 = n_ferr;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        wait_drain("drain_stream");
        repeat (4) @(negedge clk);
        chk("stream_ferr", 32'(n_ferr - f0), 0);
        chk("stream_data", 32'(bus.data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
